uart_rx_word_assembler: RTL and testbench

Controller placed directly after `UART_Receiver_Byte` in the RSA input path. It collects a fixed number of received bytes into one wide operand word (message, modulus or exponent chunk) and presents it to the RSA core with a valid/ready handshake. It times out partial words using the shared `baud_tick`, and flags bytes lost while a finished word is held.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tick_timeout.sv | 35 +++
 rtl/uart_rx_word_assembler.sv | 154 +++++++++++++++
 tb/tb_uart_rx_word_assembler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RSA input path.
// Holds oversampling constants, the default partial-word timeout and the
// word assembler FSM state encoding.
package uart_pkg;

    localparam int unsigned OVERSAMPLE     = 16;
    // 10 bit times per frame (start + 8 data + stop) at OVERSAMPLE ticks each
    localparam int unsigned TICKS_PER_BYTE = 10 * OVERSAMPLE;
    // Three idle byte times abort a partial word
    localparam int unsigned DEFAULT_TIMEOUT_TICKS = 3 * TICKS_PER_BYTE;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE    = 2'd0;
    localparam rx_state_t ST_COLLECT = 2'd1;
    localparam rx_state_t ST_HOLD    = 2'd2;

endpackage

// File: rtl/uart_tick_timeout.sv
// Saturating tick counter with synchronous clear, used as an idle watchdog.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - force count to 0 on the next edge (wins over counting)
//   enable    - allow counting
//   tick      - count strobe (one-cycle baud tick)
//   expire_c  - combinational: this enabled tick is the LIMIT-th one
module uart_tick_timeout #(
    parameter int unsigned LIMIT = 480,
    localparam int unsigned CW   = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expire_c
);

    logic [CW-1:0] count;

    // Counts enabled ticks; saturates at LIMIT so it can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    assign expire_c = enable && tick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Collects BYTES received UART bytes into one operand word for the RSA core,
// presents it with a valid/ready handshake, aborts stale partial words after
// TIMEOUT_TICKS idle baud ticks and flags bytes lost while a word is held.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   baud_tick     - 16x oversample tick shared with the receiver
//   byte_valid    - one-cycle strobe qualifying byte_data
//   byte_data     - received byte
//   word_ready    - consumer accepts word
//   word_valid    - assembled word available (registered)
//   word_data     - assembled word, first byte in MSBs (registered)
//   byte_count    - bytes held in current word (registered)
//   timeout_err   - one-cycle pulse: partial word discarded (registered)
//   overrun       - one-cycle pulse: byte dropped while holding (registered)
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned BYTES         = 4,
    parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    localparam int unsigned WW = 8 * BYTES,
    localparam int unsigned CW = $clog2(BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          baud_tick,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          word_ready,
    output logic          word_valid,
    output logic [WW-1:0] word_data,
    output logic [CW-1:0] byte_count,
    output logic          timeout_err,
    output logic          overrun
);

    rx_state_t     state, state_n;
    logic [WW-1:0] word_data_n;
    logic [CW-1:0] byte_count_n;
    logic          word_valid_n;
    logic          timeout_err_n;
    logic          overrun_n;

    logic          expire_c;
    logic          timer_clear_c;
    logic          handshake_c;
    logic [WW-1:0] shifted_c;

    assign handshake_c = word_valid && word_ready;
    // Shift left by one byte; for BYTES=1 this simply replaces the word
    assign shifted_c   = (word_data << 8) | WW'(byte_data);
    // Timer only runs while collecting; any accepted byte or abort restarts it
    assign timer_clear_c = (state != ST_COLLECT) || byte_valid || expire_c;

    uart_tick_timeout #(
        .LIMIT (TIMEOUT_TICKS)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_c),
        .enable   (state == ST_COLLECT),
        .tick     (baud_tick),
        .expire_c (expire_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_data   <= '0;
            byte_count  <= '0;
            word_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            word_data   <= word_data_n;
            byte_count  <= byte_count_n;
            word_valid  <= word_valid_n;
            timeout_err <= timeout_err_n;
            overrun     <= overrun_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n       = state;
        word_data_n   = word_data;
        byte_count_n  = byte_count;
        word_valid_n  = word_valid;
        timeout_err_n = 1'b0;
        overrun_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (byte_valid) begin
                    word_data_n  = shifted_c;
                    byte_count_n = CW'(1);
                    if (BYTES == 1) begin
                        state_n      = ST_HOLD;
                        word_valid_n = 1'b1;
                    end else begin
                        state_n = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                // A byte arriving on the expiring tick takes priority
                if (byte_valid) begin
                    word_data_n  = shifted_c;
                    byte_count_n = byte_count + CW'(1);
                    if (byte_count == CW'(BYTES - 1)) begin
                        state_n      = ST_HOLD;
                        word_valid_n = 1'b1;
                    end
                end else if (expire_c) begin
                    timeout_err_n = 1'b1;
                    byte_count_n  = '0;
                    word_data_n   = '0;
                    state_n       = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (handshake_c) begin
                    word_valid_n = 1'b0;
                    byte_count_n = '0;
                    state_n      = ST_IDLE;
                    // A byte coinciding with the handshake starts the next word
                    if (byte_valid) begin
                        word_data_n  = WW'(byte_data);
                        byte_count_n = CW'(1);
                        if (BYTES == 1) begin
                            state_n      = ST_HOLD;
                            word_valid_n = 1'b1;
                        end else begin
                            state_n = ST_COLLECT;
                        end
                    end
                end else if (byte_valid) begin
                    overrun_n = 1'b1;
                end
            end

            default: begin
                state_n      = ST_IDLE;
                word_valid_n = 1'b0;
                byte_count_n = '0;
                word_data_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Self-checking bench for uart_rx_word_assembler: a vector table, directed
// multi-cycle corner cases and randomized traffic against a queue-based model.
module tb_uart_rx_word_assembler;

    localparam int unsigned BYTES = 4;
    localparam int unsigned TO    = 480;
    localparam int unsigned CW    = $clog2(BYTES + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_tick;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          word_ready;
    logic          word_valid;
    logic [31:0]   word_data;
    logic [CW-1:0] byte_count;
    logic          timeout_err;
    logic          overrun;

    always #5 clk = ~clk;

    uart_rx_word_assembler #(
        .BYTES         (BYTES),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .byte_count  (byte_count),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: bytes of the current word kept in a queue, held word
    // captured when the queue reaches BYTES, idle ticks counted since last byte.
    logic [7:0]  q[$];
    logic [31:0] m_held;
    bit          m_valid;
    int          m_ticks;
    bit          m_to;
    bit          m_ov;

    function automatic logic [31:0] pack_q();
        logic [31:0] w = 32'h0;
        foreach (q[i]) w = (w << 8) | 32'(q[i]);
        return w;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_held  = 32'h0;
        m_valid = 1'b0;
        m_ticks = 0;
        m_to    = 1'b0;
        m_ov    = 1'b0;
    endfunction

    function automatic void model_step(input bit bv, input logic [7:0] bd, input bit rdy, input bit tk);
        m_to = 1'b0;
        m_ov = 1'b0;
        if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                q.delete();
                m_ticks = 0;
                if (bv) q.push_back(bd);
            end else if (bv) begin
                m_ov = 1'b1;
            end
        end else if (bv) begin
            q.push_back(bd);
            m_ticks = 0;
        end else if (q.size() != 0 && tk) begin
            m_ticks++;
            if (m_ticks == int'(TO)) begin
                m_to = 1'b1;
                q.delete();
                m_ticks = 0;
            end
        end
        if (!m_valid && q.size() == int'(BYTES)) begin
            m_valid = 1'b1;
            m_held  = pack_q();
            q.delete();
        end
    endfunction

    // One clock: drive at negedge, sample 1 ns after the rising edge
    task automatic cycle(input bit bv, input logic [7:0] bd, input bit rdy, input bit tk);
        @(negedge clk);
        byte_valid = bv;
        byte_data  = bd;
        word_ready = rdy;
        baud_tick  = tk;
        model_step(bv, bd, rdy, tk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, ".count"}, 32'(byte_count), m_valid ? 32'(BYTES) : 32'(q.size()));
        chk({tag, ".timeout"}, 32'(timeout_err), 32'(m_to));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
        if (m_valid) chk({tag, ".data"}, word_data, m_held);
    endtask

    // n idle ticks spaced 10 clocks apart; only the final tick may time out
    task automatic idle_ticks(input int n, input bit last_to, input string tag);
        for (int k = 0; k < n; k++) begin
            repeat (9) cycle(1'b0, 8'h00, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            chk(tag, 32'(timeout_err), 32'(last_to && (k == n - 1)));
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int i = 3; i >= 0; i--) cycle(1'b1, w[8*i +: 8], rdy, 1'b0);
    endtask

    typedef struct {
        bit          bv;
        logic [7:0]  bd;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_data;
        int          e_cnt;
        bit          e_ov;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int quiet;
        bit bv, rdy, tk;

        rst = 1'b1; baud_tick = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; word_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.valid", 32'(word_valid), 32'h0);
        chk("reset.data", word_data, 32'h0);
        chk("reset.count", 32'(byte_count), 32'h0);
        chk("reset.timeout", 32'(timeout_err), 32'h0);
        chk("reset.overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic word, held word with overrun, handshake coinciding with a byte
        tbl.push_back('{1'b1, 8'h12, 1'b1, 1'b0, 32'h0, 1, 1'b0});
        tbl.push_back('{1'b1, 8'h34, 1'b1, 1'b0, 32'h0, 2, 1'b0});
        tbl.push_back('{1'b1, 8'h56, 1'b1, 1'b0, 32'h0, 3, 1'b0});
        tbl.push_back('{1'b1, 8'h78, 1'b1, 1'b1, 32'h12345678, 4, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'h12, 1'b0, 1'b0, 32'h0, 1, 1'b0});
        tbl.push_back('{1'b1, 8'h34, 1'b0, 1'b0, 32'h0, 2, 1'b0});
        tbl.push_back('{1'b1, 8'h56, 1'b0, 1'b0, 32'h0, 3, 1'b0});
        tbl.push_back('{1'b1, 8'h78, 1'b0, 1'b1, 32'h12345678, 4, 1'b0});
        tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 32'h12345678, 4, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678, 4, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 0, 1'b0});
        tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 1, 1'b0});
        tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 2, 1'b0});
        tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 32'h0, 3, 1'b0});
        tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 32'h11223344, 4, 1'b0});
        tbl.push_back('{1'b1, 8'h9C, 1'b1, 1'b0, 32'h0, 1, 1'b0});
        tbl.push_back('{1'b1, 8'hA1, 1'b0, 1'b0, 32'h0, 2, 1'b0});
        tbl.push_back('{1'b1, 8'hB2, 1'b0, 1'b0, 32'h0, 3, 1'b0});
        tbl.push_back('{1'b1, 8'hC3, 1'b0, 1'b1, 32'h9CA1B2C3, 4, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 0, 1'b0});

        foreach (tbl[i]) begin
            cycle(tbl[i].bv, tbl[i].bd, tbl[i].rdy, 1'b0);
            chk($sformatf("vec%0d.valid", i), 32'(word_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.count", i), 32'(byte_count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout_err), 32'h0);
            if (tbl[i].e_valid) chk($sformatf("vec%0d.data", i), word_data, tbl[i].e_data);
        end

        // Partial word aborted after TO idle ticks, then a clean word
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("to.count_before", 32'(byte_count), 32'h2);
        idle_ticks(TO, 1'b1, "to.pulse");
        chk("to.count_after", 32'(byte_count), 32'h0);
        chk("to.data_cleared", word_data, 32'h0);
        chk("to.no_valid", 32'(word_valid), 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("to.one_cycle", 32'(timeout_err), 32'h0);
        send_word(32'h01020304, 1'b1);
        chk("to.next_valid", 32'(word_valid), 32'h1);
        chk("to.next_data", word_data, 32'h01020304);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("to.next_done", 32'(word_valid), 32'h0);

        // Byte on the exact expiring tick wins and restarts the timer
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        idle_ticks(TO - 1, 1'b0, "race.pre");
        repeat (9) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h88, 1'b1, 1'b1);
        chk("race.count", 32'(byte_count), 32'h2);
        chk("race.no_timeout", 32'(timeout_err), 32'h0);
        idle_ticks(TO, 1'b1, "race.restart");
        chk("race.count_after", 32'(byte_count), 32'h0);

        // Asynchronous reset mid-word clears everything without an error pulse
        cycle(1'b1, 8'h01, 1'b1, 1'b0);
        cycle(1'b1, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.count", 32'(byte_count), 32'h0);
        chk("rst.data", word_data, 32'h0);
        chk("rst.valid", 32'(word_valid), 32'h0);
        chk("rst.timeout", 32'(timeout_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_word(32'hDEADBEEF, 1'b1);
        chk("rst.next_data", word_data, 32'hDEADBEEF);
        chk("rst.next_valid", 32'(word_valid), 32'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst.next_done", 32'(byte_count), 32'h0);

        // Randomized traffic with occasional tick-dense quiet stretches
        quiet = 0;
        for (int n = 0; n < 4000; n++) begin
            if (quiet > 0) begin
                quiet--;
                cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                bv  = ($urandom_range(0, 99) < 35);
                rdy = ($urandom_range(0, 99) < 50);
                tk  = ($urandom_range(0, 9) == 0);
                cycle(bv, 8'($urandom), rdy, tk);
                if ($urandom_range(0, 199) == 0) quiet = $urandom_range(470, 500);
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
